// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared types and helpers for the mem_dp_ram family.
//   - clr_state_t : clear sequencer state encoding
//   - NB          : byte lanes for the library default data width
//   - nb()        : byte lanes for an arbitrary data width
//   - clog2()     : ceiling log2, used to size array indices
//   - rd_lat_ok() : read-latency legality, checked at elaboration by the top
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam int DATA_W_DFLT = 8;
    localparam int NB          = DATA_W_DFLT / 8;

    function automatic int nb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/mem_dp_ram_clear.sv
// ---------------------------------------------------------------------------
// mem_clear_seq
//   Zeroes the RAM one word per cycle after reset.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | writing zero to word cnt; busy high; user requests dropped
//   READY | array usable; sequencer idle
//
// Ports
//   clk      : clock
//   rst      : synchronous active-high reset; (re)starts the clear at word 0
//   busy     : high exactly while in CLEAR
//   clr_we   : write strobe for the zero word
//   clr_addr : word being cleared this cycle
// ---------------------------------------------------------------------------
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    clr_state_t        state_n;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_EN != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        busy    = 1'b0;
        clr_we  = 1'b0;
        unique case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_n = READY;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ADDR_W'(1);
                end
            end
            READY: begin
                state_n = READY;
            end
            default: begin
                state_n = READY;
                cnt_n   = '0;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/mem_dp_ram.sv
// ---------------------------------------------------------------------------
// mem_dp_ram
//   Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read
//   latency, selectable read-during-write behaviour and a post-reset clear.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/addr/data/be: write port; be bit i gates data byte i
//   rd_en/addr        : read request
//   rd_data, rd_valid : read result, valid for one cycle per accepted read
//   busy              : clear running, requests dropped
//   err_oob           : one-cycle pulse for an accepted out-of-range access
// ---------------------------------------------------------------------------
module mem_dp_ram
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0,
    parameter int CLEAR_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  err_oob
);

    localparam int NB_W  = nb(DATA_W);
    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_dp_ram: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("mem_dp_ram: DATA_W must be a multiple of 8");
    end
    if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("mem_dp_ram: DEPTH exceeds address space");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    mem_clear_seq #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .CLEAR_EN (CLEAR_EN)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Requests are only looked at when the sequencer is idle and not in reset.
    logic accept;
    logic wr_acc, rd_acc;
    logic wr_in, rd_in;
    logic wr_ok, rd_ok;
    logic oob_any;

    assign accept  = ~rst & ~busy;
    assign wr_acc  = accept & wr_en;
    assign rd_acc  = accept & rd_en;
    assign wr_in   = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in   = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_ok   = wr_acc & wr_in;
    assign rd_ok   = rd_acc & rd_in;
    assign oob_any = (wr_acc & ~wr_in) | (rd_acc & ~rd_in);

    logic [IDX_W-1:0] wr_idx, rd_idx, clr_idx;
    assign wr_idx  = wr_addr[IDX_W-1:0];
    assign rd_idx  = rd_addr[IDX_W-1:0];
    assign clr_idx = clr_addr[IDX_W-1:0];

    // The clear sequencer owns the write port while busy; user writes are
    // already masked by accept, so the priority here never drops a request.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read word as it appears to the requester. The array read sees the
    // pre-edge contents; write-first mode overlays the enabled write bytes.
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_next;
    logic              collide;

    assign collide = (WR_FIRST != 0) && wr_ok && rd_ok && (wr_addr == rd_addr);

    always_comb begin
        rd_word = mem[rd_idx];
        rd_next = '0;
        if (rd_ok) begin
            rd_next = rd_word;
            if (collide) begin
                for (int i = 0; i < NB_W; i++) begin
                    if (wr_be[i]) begin
                        rd_next[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Stage 1: array output register. Data only moves on an accepted read so
    // the output holds its last value between valids.
    logic [DATA_W-1:0] rd_data_s1;
    logic              rd_valid_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            rd_valid_s1 <= rd_acc;
            err_oob     <= oob_any;
            if (rd_acc) begin
                rd_data_s1 <= rd_next;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd_data_s2;
        logic              rd_valid_s2;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_s2  <= '0;
                rd_valid_s2 <= 1'b0;
            end else begin
                rd_valid_s2 <= rd_valid_s1;
                if (rd_valid_s1) begin
                    rd_data_s2 <= rd_data_s1;
                end
            end
        end

        assign rd_data  = rd_data_s2;
        assign rd_valid = rd_valid_s2;
    end else begin : g_lat1
        assign rd_data  = rd_data_s1;
        assign rd_valid = rd_valid_s1;
    end

endmodule

// File: tb/tb_mem_dp_ram.sv
// ---------------------------------------------------------------------------
// tb_mem_dp_ram
//   Four RAM configurations share one stimulus stream; each has its own
//   reference model (word array + per-cycle expected read results).
//   u0: DEPTH 12, RD_LAT 1, read-first,  clear on
//   u1: DEPTH 16, RD_LAT 2, write-first, clear on
//   u2: DEPTH 16, RD_LAT 1, write-first, clear off
//   u3: DEPTH 16, RD_LAT 2, read-first,  clear on
// ---------------------------------------------------------------------------
module tb_mem_dp_ram;

    localparam int NU = 4;
    localparam int DEP [NU] = '{12, 16, 16, 16};
    localparam int LAT [NU] = '{1, 2, 1, 2};
    localparam int WF  [NU] = '{0, 1, 1, 0};
    localparam int CE  [NU] = '{1, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic [NU-1:0][31:0] rd_data_u;
    logic [NU-1:0]       rd_valid_u;
    logic [NU-1:0]       busy_u;
    logic [NU-1:0]       err_u;

    always #5 clk = ~clk;

    mem_dp_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEP[0]), .RD_LAT(LAT[0]),
                 .WR_FIRST(WF[0]), .CLEAR_EN(CE[0])) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_u[0]),
        .rd_valid(rd_valid_u[0]), .busy(busy_u[0]), .err_oob(err_u[0]));

    mem_dp_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEP[1]), .RD_LAT(LAT[1]),
                 .WR_FIRST(WF[1]), .CLEAR_EN(CE[1])) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_u[1]),
        .rd_valid(rd_valid_u[1]), .busy(busy_u[1]), .err_oob(err_u[1]));

    mem_dp_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEP[2]), .RD_LAT(LAT[2]),
                 .WR_FIRST(WF[2]), .CLEAR_EN(CE[2])) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_u[2]),
        .rd_valid(rd_valid_u[2]), .busy(busy_u[2]), .err_oob(err_u[2]));

    mem_dp_ram #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEP[3]), .RD_LAT(LAT[3]),
                 .WR_FIRST(WF[3]), .CLEAR_EN(CE[3])) u3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_u[3]),
        .rd_valid(rd_valid_u[3]), .busy(busy_u[3]), .err_oob(err_u[3]));

    // reference model state
    logic [31:0] m_mem   [NU][16];
    bit          m_known [NU][16];
    int          clear_left [NU];
    bit          ev [NU][4];
    logic [31:0] ed [NU][4];
    bit          ek [NU][4];
    logic [31:0] last_d [NU];
    bit          last_k [NU];
    bit          exp_err [NU];
    int          cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Advance the model over one clock edge using the currently driven
    // inputs, then compare every unit's outputs just after the edge.
    task automatic step();
        for (int u = 0; u < NU; u++) begin
            exp_err[u] = 1'b0;
            if (rst) begin
                clear_left[u] = (CE[u] != 0) ? DEP[u] : 0;
                for (int s = 0; s < 4; s++) ev[u][s] = 1'b0;
                last_d[u] = 32'h0;
                last_k[u] = 1'b1;
            end else if (clear_left[u] > 0) begin
                clear_left[u]--;
                if (clear_left[u] == 0) begin
                    for (int a = 0; a < 16; a++) begin
                        m_mem[u][a]   = 32'h0;
                        m_known[u][a] = 1'b1;
                    end
                end
            end else begin
                if (rd_en) begin
                    int due;
                    logic [31:0] d;
                    bit k;
                    due = cyc + LAT[u];
                    if (int'(rd_addr) < DEP[u]) begin
                        d = m_mem[u][rd_addr];
                        k = m_known[u][rd_addr];
                        if (WF[u] != 0 && wr_en && wr_addr == rd_addr) begin
                            d = merge_be(d, wr_data, wr_be);
                            k = k || (wr_be == 4'hF);
                        end
                    end else begin
                        d = 32'h0;
                        k = 1'b1;
                        exp_err[u] = 1'b1;
                    end
                    ev[u][due % 4] = 1'b1;
                    ed[u][due % 4] = d;
                    ek[u][due % 4] = k;
                end
                if (wr_en) begin
                    if (int'(wr_addr) < DEP[u]) begin
                        m_mem[u][wr_addr]   = merge_be(m_mem[u][wr_addr], wr_data, wr_be);
                        m_known[u][wr_addr] = m_known[u][wr_addr] || (wr_be == 4'hF);
                    end else begin
                        exp_err[u] = 1'b1;
                    end
                end
            end
        end

        @(posedge clk);
        cyc++;
        #1;

        for (int u = 0; u < NU; u++) begin
            int s;
            s = cyc % 4;
            check($sformatf("u%0d busy", u), {31'h0, busy_u[u]}, {31'h0, clear_left[u] > 0});
            check($sformatf("u%0d rd_valid", u), {31'h0, rd_valid_u[u]}, {31'h0, ev[u][s]});
            check($sformatf("u%0d err_oob", u), {31'h0, err_u[u]}, {31'h0, exp_err[u]});
            if (ev[u][s]) begin
                if (ek[u][s]) check($sformatf("u%0d rd_data", u), rd_data_u[u], ed[u][s]);
                last_d[u] = ed[u][s];
                last_k[u] = ek[u][s];
                ev[u][s]  = 1'b0;
            end else if (last_k[u]) begin
                check($sformatf("u%0d rd_data hold", u), rd_data_u[u], last_d[u]);
            end
        end
    endtask

    task automatic req(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic rand_req(input int rd_pct, input int wr_pct);
        req(($urandom_range(0, 99) < wr_pct), 4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 99) < rd_pct),
            4'($urandom_range(0, 15)));
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            clear_left[u] = 0;
            last_d[u]     = 32'h0;
            last_k[u]     = 1'b0;
            exp_err[u]    = 1'b0;
            for (int s = 0; s < 4; s++) ev[u][s] = 1'b0;
            for (int a = 0; a < 16; a++) begin
                m_mem[u][a]   = 32'h0;
                m_known[u][a] = 1'b0;
            end
        end
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0; wr_be = 4'h0;
        rd_en = 1'b0; rd_addr = 4'h0;

        // reset, then requests while the clear runs
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) rand_req(70, 50);
        idle(2);

        // whole array reads back as zero for the cleared units
        for (int a = 0; a < 16; a++) req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
        idle(2);

        // byte-enable merge
        req(1'b1, 4'd5, 32'hAABBCCDD, 4'b1111, 1'b0, 4'h0);
        req(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0, 4'h0);
        req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd5);
        check("be merge u0", rd_data_u[0], 32'hAA22CC44);
        idle(1);
        check("be merge u1 lat2", rd_data_u[1], 32'hAA22CC44);

        // read-during-write collision
        req(1'b1, 4'd3, 32'h00000055, 4'hF, 1'b0, 4'h0);
        req(1'b1, 4'd3, 32'h00000066, 4'hF, 1'b1, 4'd3);
        check("collide rd-first u0", rd_data_u[0], 32'h00000055);
        check("collide wr-first u2", rd_data_u[2], 32'h00000066);
        idle(1);
        check("collide wr-first u1", rd_data_u[1], 32'h00000066);
        check("collide rd-first u3", rd_data_u[3], 32'h00000055);

        // back-to-back reads
        for (int a = 0; a < 3; a++) req(1'b1, 4'(a), 32'hC0DE0000 + a, 4'hF, 1'b0, 4'h0);
        for (int a = 0; a < 3; a++) req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
        idle(3);

        // out of range on the 12-deep unit
        req(1'b1, 4'd13, 32'h00000077, 4'hF, 1'b0, 4'h0);
        check("oob wr err u0", {31'h0, err_u[0]}, 32'h1);
        req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd13);
        check("oob rd valid u0", {31'h0, rd_valid_u[0]}, 32'h1);
        check("oob rd data u0", rd_data_u[0], 32'h0);
        req(1'b1, 4'd14, 32'h1, 4'hF, 1'b1, 4'd15);
        for (int a = 0; a < 16; a++) req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
        idle(2);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            rand_req(50, 50);
        end
        rst = 1'b0;
        idle(20);

        // reset while the clear counter is at 7, reads attempted throughout
        rst = 1'b1;
        req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) rand_req(100, 50);
        rst = 1'b1;
        req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd2);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) rand_req(100, 50);
        idle(2);
        for (int a = 0; a < 16; a++) req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_dp_ram.md
Name: mem_dp_ram

Overview:
- Parametrised simple-dual-port synchronous RAM; successor to the fixed 1K x 8 single-port RAM in the memory library.
- Provides an independent write port and read port, per-byte write enables, and a selectable read latency of 1 or 2 cycles.
- Selectable read-during-write collision mode.
- Hardware clear sequencer zeroes the array after reset; a busy flag is raised while it runs.
- Used as a generic scratch and line buffer by datapath blocks.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_FIRST, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_EN, 1, 1 = zero the array after reset; 0 = skip the clear.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, DATA_W: write data.
- wr_be, input, DATA_W/8: byte enables; bit i gates wr_data[8i+7:8i].
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_W: read address.
- rd_data, output, DATA_W: read data.
- rd_valid, output, 1: rd_data is valid this cycle.
- busy, output, 1: clear in progress; all requests are ignored.
- err_oob, output, 1: one-cycle pulse when an accepted request addresses >= DEPTH.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: rd_data = 0, rd_valid = 0, err_oob = 0, all pipeline stages cleared, clear counter = 0.
- busy after reset: 1 if CLEAR_EN = 1, else 0.
- rst does not itself clear array contents; only the clear sequencer does.
- Clear FSM, states CLEAR and READY:
  - rst enters CLEAR when CLEAR_EN = 1, otherwise READY.
  - In CLEAR, one word is written to 0 per cycle at address = counter, counter runs 0..DEPTH-1.
  - On the cycle the counter reaches DEPTH-1, that word is cleared and the FSM moves to READY next cycle.
  - busy = 1 exactly while in CLEAR; total clear time is DEPTH cycles.
  - rst asserted mid-clear restarts the clear from address 0.
- While busy:
  - wr_en and rd_en are ignored: no write, no rd_valid, no err_oob.
  - Requests are dropped, not queued.
- Write (READY, wr_en = 1, wr_addr < DEPTH):
  - At the clock edge, mem[wr_addr] byte i <= wr_data byte i for each wr_be[i] = 1; other bytes unchanged.
  - wr_be = 0 is a legal no-op.
- Read (READY, rd_en = 1, rd_addr < DEPTH), request accepted at edge N:
  - RD_LAT = 1: rd_data/rd_valid update at edge N+1.
  - RD_LAT = 2: the array output passes through one extra register; rd_data/rd_valid update at edge N+2.
  - rd_valid is a one-cycle pulse per accepted read; back-to-back reads give back-to-back valids.
  - rd_data holds its last value when rd_valid = 0.
- Collision (same cycle, wr_en and rd_en, same address, READY):
  - WR_FIRST = 0: read returns the pre-write word.
  - WR_FIRST = 1: read returns the post-write word, merged per wr_be.
- Out of range (address >= DEPTH):
  - Write is suppressed.
  - Read produces rd_valid with rd_data = 0 at the normal latency.
  - err_oob pulses 1 cycle after the request; a simultaneous bad write and bad read give a single pulse.
- No internal state other than the array, read pipeline, FSM and counter.

Decomposition:
- Shared package mem_pkg:
  - typedef for the clear FSM state enum.
  - localparam NB = DATA_W/8.
  - function clog2.
  - RD_LAT legality check (elaboration-time assertion).
- One natural sub-module, mem_clear_seq: FSM plus counter, outputs busy, clr_we, clr_addr.
- Top level muxes clear writes over the user write port.

Test Plan:
- CLEAR_EN = 1, DEPTH = 16: pulse rst, then read all 16 addresses after busy falls -> busy high exactly 16 cycles; every read returns 0x00.
- DATA_W = 32, write addr 5 = 0xAABBCCDD with wr_be = 4'b1111, then write 0x11223344 with wr_be = 4'b0101 -> read of addr 5 returns 0xAA22CC44.
- RD_LAT = 2, rd_en at edges 10, 11, 12 -> rd_valid high at edges 12, 13, 14 with the matching data.
- Addr 3 holds 0x55; simultaneous write 0x66 and read at addr 3 -> WR_FIRST = 0 returns 0x55; WR_FIRST = 1 returns 0x66.
- DEPTH = 12, ADDR_W = 4: write 0x77 to addr 13, then read addr 13 -> err_oob pulses; rd_data = 0 with rd_valid; addrs 0..11 unchanged.
- Assert rst at clear counter = 7, plus rd_en while busy -> clear restarts at 0; busy lasts DEPTH cycles after the last rst; no rd_valid.
